pb_io_arbiter: RTL and testbench

Round-robin arbiter that shares one PicoBlaze-style 8-bit peripheral I/O bus between up to NUM_REQ requesters, such as several KCPSM cores or a core plus a debug master. It sits beside system_controller in the top level, clocked by its CLK_OUT and reset by its reset output. The arbiter grants one requester at a time and drives the single shared bus cycle. It returns the acknowledge and read data to the granted requester, and terminates hung cycles with a timeout error.

---
 rtl/pb_io_arbiter_if.sv | 34 +++
 rtl/pb_io_arbiter.sv | 162 ++++++++++++++++
 tb/tb_pb_io_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pb_io_arbiter_if.sv
// Shared PicoBlaze-style I/O bus bundle between the requesters, the arbiter and the bus slave.
// The arbiter connects to the slave modport; the environment connects to the master modport.
interface pb_io_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            REQ_IN;
  logic [NUM_REQ-1:0]            WE_IN;
  logic [NUM_REQ*ADDR_WIDTH-1:0] ADDR_IN;
  logic [NUM_REQ*DATA_WIDTH-1:0] WDATA_IN;
  logic [NUM_REQ-1:0]            GNT_OUT;
  logic [NUM_REQ-1:0]            ACK_OUT;
  logic [NUM_REQ-1:0]            ERR_OUT;
  logic [DATA_WIDTH-1:0]         RDATA_OUT;
  logic                          BUS_CYC_OUT;
  logic                          BUS_WE_OUT;
  logic [ADDR_WIDTH-1:0]         BUS_ADDR_OUT;
  logic [DATA_WIDTH-1:0]         BUS_WDATA_OUT;
  logic                          BUS_ACK_IN;
  logic [DATA_WIDTH-1:0]         BUS_RDATA_IN;

  modport slave (
    input  REQ_IN, WE_IN, ADDR_IN, WDATA_IN, BUS_ACK_IN, BUS_RDATA_IN,
    output GNT_OUT, ACK_OUT, ERR_OUT, RDATA_OUT,
    output BUS_CYC_OUT, BUS_WE_OUT, BUS_ADDR_OUT, BUS_WDATA_OUT
  );

  modport master (
    output REQ_IN, WE_IN, ADDR_IN, WDATA_IN, BUS_ACK_IN, BUS_RDATA_IN,
    input  GNT_OUT, ACK_OUT, ERR_OUT, RDATA_OUT,
    input  BUS_CYC_OUT, BUS_WE_OUT, BUS_ADDR_OUT, BUS_WDATA_OUT
  );
endinterface

// File: rtl/pb_io_arbiter.sv
// Round-robin arbiter driving one shared 8-bit peripheral bus cycle at a time,
// with a bounded wait for the slave acknowledge and a timeout error pulse.
module pb_io_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic               CLK_IN,
  input  logic               RESET_IN,
  pb_io_arbiter_if.slave     io
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         win_q, win_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic [NUM_REQ-1:0]    err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  pick_found_s;
  logic [PW-1:0]         pick_idx_s;

  // Round-robin search: first requester at or above ptr_q, wrapping past NUM_REQ-1.
  always_comb begin
    int idx;
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    idx          = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!pick_found_s && io.REQ_IN[idx]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = PW'(idx);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          win_d   = pick_idx_s;
          gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
          we_d    = io.WE_IN[pick_idx_s];
          addr_d  = io.ADDR_IN[int'(pick_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = io.WDATA_IN[int'(pick_idx_s)*DATA_WIDTH +: DATA_WIDTH];
          cyc_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        // The acknowledge is checked first so an ack on the timeout cycle is not an error.
        if (io.BUS_ACK_IN) begin
          if (!we_q) begin
            rdata_d = io.BUS_RDATA_IN;
          end else begin
            rdata_d = rdata_q;
          end
          ack_d   = gnt_q;
          gnt_d   = '0;
          cyc_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == 8'(TIMEOUT)) begin
          ack_d   = gnt_q;
          err_d   = gnt_q;
          rdata_d = '1;
          gnt_d   = '0;
          cyc_d   = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        gnt_d = '0;
        if (int'(win_q) == NUM_REQ - 1) begin
          ptr_d = '0;
        end else begin
          ptr_d = win_q + PW'(1);
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any bus cycle in flight.
  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= 8'd0;
      gnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign io.GNT_OUT       = gnt_q;
  assign io.ACK_OUT       = ack_q;
  assign io.ERR_OUT       = err_q;
  assign io.RDATA_OUT     = rdata_q;
  assign io.BUS_CYC_OUT   = cyc_q;
  assign io.BUS_WE_OUT    = we_q;
  assign io.BUS_ADDR_OUT  = addr_q;
  assign io.BUS_WDATA_OUT = wdata_q;

endmodule

// File: tb/tb_pb_io_arbiter.sv
// Self-checking bench for pb_io_arbiter: directed scenarios plus randomized transfers
// checked against a transaction-level round-robin / timeout reference model.
module tb_pb_io_arbiter;

  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 15;

  logic CLK_IN   = 1'b0;
  logic RESET_IN = 1'b0;

  always #5 CLK_IN = ~CLK_IN;

  pb_io_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  pb_io_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .CLK_IN   (CLK_IN),
    .RESET_IN (RESET_IN),
    .io       (bus.slave)
  );

  typedef struct {
    int             win;
    int             cyc_len;
    int             ack_cyc;
    logic [NR-1:0]  ack;
    logic [NR-1:0]  err;
    logic [DW-1:0]  rd;
    logic           we;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic           stable;
    logic           gnt_ok;
    logic           hung;
  } obs_t;

  int            n_checks  = 0;
  int            n_fail    = 0;
  int            model_ptr = 0;
  logic [DW-1:0] model_rd  = 8'h00;

  logic          r_we    [NR];
  logic [AW-1:0] r_addr  [NR];
  logic [DW-1:0] r_wdata [NR];

  // Reference arbitration rule: first requester at or after ptr, wrapping.
  function automatic int rr_pick(input logic [NR-1:0] req, input int ptr);
    for (int k = 0; k < NR; k++) begin
      if (req[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic load_inputs();
    for (int i = 0; i < NR; i++) begin
      bus.WE_IN[i]              = r_we[i];
      bus.ADDR_IN[i*AW +: AW]   = r_addr[i];
      bus.WDATA_IN[i*DW +: DW]  = r_wdata[i];
    end
  endtask

  // Drives one request set and plays a slave that acks after 'lat' wait cycles
  // (never, if lat > TO). Returns what was observed; ends in the ACK cycle.
  task automatic do_xfer(input logic [NR-1:0] req, input int lat, input logic [DW-1:0] srd,
                         output obs_t o);
    logic [NR-1:0] g0;
    int k;
    o.win = -1; o.cyc_len = 0; o.ack_cyc = 0; o.ack = '0; o.err = '0; o.rd = '0;
    o.we = 1'b0; o.addr = '0; o.wdata = '0; o.stable = 1'b1; o.gnt_ok = 1'b1; o.hung = 1'b1;
    @(negedge CLK_IN);
    load_inputs();
    bus.REQ_IN       = req;
    bus.BUS_ACK_IN   = 1'b0;
    bus.BUS_RDATA_IN = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK_IN);
      o.ack_cyc++;
      if (|bus.GNT_OUT) begin
        o.hung = 1'b0;
        break;
      end
    end
    if (o.hung) return;
    for (int i = 0; i < NR; i++) if (bus.GNT_OUT[i]) o.win = i;
    g0      = bus.GNT_OUT;
    o.gnt_ok = $onehot(bus.GNT_OUT);
    o.we    = bus.BUS_WE_OUT;
    o.addr  = bus.BUS_ADDR_OUT;
    o.wdata = bus.BUS_WDATA_OUT;
    o.hung  = 1'b1;
    k = 0;
    while (k < 300) begin
      if (!bus.BUS_CYC_OUT) begin
        o.hung = 1'b0;
        break;
      end
      o.cyc_len++;
      if (bus.BUS_WE_OUT !== o.we || bus.BUS_ADDR_OUT !== o.addr ||
          bus.BUS_WDATA_OUT !== o.wdata || bus.ACK_OUT !== 4'b0000) o.stable = 1'b0;
      if (bus.GNT_OUT !== g0) o.gnt_ok = 1'b0;
      bus.BUS_ACK_IN   = (k == lat);
      bus.BUS_RDATA_IN = (k == lat) ? srd : 8'($urandom);
      bus.ADDR_IN      = 32'($urandom);
      bus.WDATA_IN     = 32'($urandom);
      bus.WE_IN        = 4'($urandom);
      k++;
      o.ack_cyc++;
      @(negedge CLK_IN);
    end
    bus.BUS_ACK_IN = 1'b0;
    if (o.hung) return;
    o.ack = bus.ACK_OUT;
    o.err = bus.ERR_OUT;
    o.rd  = bus.RDATA_OUT;
    if (bus.GNT_OUT !== 4'b0000) o.gnt_ok = 1'b0;
    bus.REQ_IN[o.win] = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge CLK_IN);
    RESET_IN         = 1'b0;
    bus.REQ_IN       = '0;
    bus.WE_IN        = '0;
    bus.ADDR_IN      = '0;
    bus.WDATA_IN     = '0;
    bus.BUS_ACK_IN   = 1'b0;
    bus.BUS_RDATA_IN = '0;
    repeat (2) @(negedge CLK_IN);
    RESET_IN  = 1'b1;
    model_ptr = 0;
    model_rd  = 8'h00;
  endtask

  task automatic test_reset();
    @(negedge CLK_IN);
    RESET_IN = 1'b0;
    bus.REQ_IN = '0; bus.WE_IN = '0; bus.ADDR_IN = '0; bus.WDATA_IN = '0;
    bus.BUS_ACK_IN = 1'b0; bus.BUS_RDATA_IN = '0;
    repeat (2) @(negedge CLK_IN);
    n_checks++; if (bus.GNT_OUT !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", bus.GNT_OUT); end
    n_checks++; if (bus.ACK_OUT !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", bus.ACK_OUT); end
    n_checks++; if (bus.ERR_OUT !== 4'b0000) begin n_fail++; $display("FAIL reset_err: got %b want 0000", bus.ERR_OUT); end
    n_checks++; if (bus.BUS_CYC_OUT !== 1'b0) begin n_fail++; $display("FAIL reset_cyc: got %b want 0", bus.BUS_CYC_OUT); end
    n_checks++; if ({bus.BUS_WE_OUT, bus.BUS_ADDR_OUT, bus.BUS_WDATA_OUT, bus.RDATA_OUT} !== 25'd0) begin
      n_fail++; $display("FAIL reset_bus: got we=%b addr=%h wdata=%h rdata=%h want all 0",
                         bus.BUS_WE_OUT, bus.BUS_ADDR_OUT, bus.BUS_WDATA_OUT, bus.RDATA_OUT); end
    RESET_IN  = 1'b1;
    model_ptr = 0;
    model_rd  = 8'h00;
    @(negedge CLK_IN);
    n_checks++; if (bus.BUS_CYC_OUT !== 1'b0) begin n_fail++; $display("FAIL idle_no_req_cyc: got %b want 0", bus.BUS_CYC_OUT); end
  endtask

  task automatic test_single_write();
    obs_t o;
    r_we[1] = 1'b1; r_addr[1] = 8'h12; r_wdata[1] = 8'hA5;
    do_xfer(4'b0010, 0, 8'h00, o);
    bus.REQ_IN = '0;
    n_checks++; if (o.hung !== 1'b0) begin n_fail++; $display("FAIL wr_hung: got %b want 0", o.hung); end
    n_checks++; if (o.win !== 1) begin n_fail++; $display("FAIL wr_gnt: got %0d want 1", o.win); end
    n_checks++; if ({o.we, o.addr, o.wdata} !== {1'b1, 8'h12, 8'hA5}) begin
      n_fail++; $display("FAIL wr_bus: got we=%b addr=%h wdata=%h want 1/12/a5", o.we, o.addr, o.wdata); end
    n_checks++; if (o.ack !== 4'b0010 || o.err !== 4'b0000) begin
      n_fail++; $display("FAIL wr_ack_err: got ack=%b err=%b want 0010/0000", o.ack, o.err); end
    n_checks++; if (o.ack_cyc !== 2 || o.cyc_len !== 1) begin
      n_fail++; $display("FAIL wr_timing: got ack_cyc=%0d cyc_len=%0d want 2/1", o.ack_cyc, o.cyc_len); end
    n_checks++; if (o.rd !== model_rd) begin n_fail++; $display("FAIL wr_rdata_kept: got %h want %h", o.rd, model_rd); end
    n_checks++; if (o.stable !== 1'b1 || o.gnt_ok !== 1'b1) begin
      n_fail++; $display("FAIL wr_stable: got stable=%b gnt_ok=%b want 1/1", o.stable, o.gnt_ok); end
    @(negedge CLK_IN);
    n_checks++; if (bus.ACK_OUT !== 4'b0000) begin n_fail++; $display("FAIL wr_ack_pulse: got %b want 0000", bus.ACK_OUT); end
    model_ptr = 2;
  endtask

  task automatic test_read_wait();
    obs_t o;
    r_we[2] = 1'b0; r_addr[2] = 8'h40; r_wdata[2] = 8'h00;
    do_xfer(4'b0100, 3, 8'h3C, o);
    bus.REQ_IN = '0;
    n_checks++; if (o.win !== 2 || o.hung !== 1'b0) begin n_fail++; $display("FAIL rd_gnt: got %0d hung=%b want 2", o.win, o.hung); end
    n_checks++; if (o.cyc_len !== 4) begin n_fail++; $display("FAIL rd_cyc_len: got %0d want 4", o.cyc_len); end
    n_checks++; if ({o.we, o.addr} !== {1'b0, 8'h40}) begin n_fail++; $display("FAIL rd_bus: got we=%b addr=%h want 0/40", o.we, o.addr); end
    n_checks++; if (o.rd !== 8'h3C || o.ack !== 4'b0100 || o.err !== 4'b0000) begin
      n_fail++; $display("FAIL rd_data: got rd=%h ack=%b err=%b want 3c/0100/0000", o.rd, o.ack, o.err); end
    model_rd  = 8'h3C;
    model_ptr = 3;
  endtask

  task automatic test_round_robin();
    obs_t o;
    int order [5];
    logic [NR-1:0] seen;
    order = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int i = 0; i < NR; i++) begin
      r_we[i] = 1'b1; r_addr[i] = 8'(8'h10 + i); r_wdata[i] = 8'(8'h20 + i);
    end
    seen = '0;
    for (int t = 0; t < 5; t++) begin
      do_xfer(4'b1111, t % 2, 8'h00, o);
      n_checks++; if (o.win !== order[t] || o.addr !== r_addr[order[t]]) begin
        n_fail++; $display("FAIL rr_order_%0d: got %0d addr=%h want %0d", t, o.win, o.addr, order[t]); end
      if (t < NR) begin
        n_checks++; if (o.win < 0 || seen[o.win] !== 1'b0) begin
          n_fail++; $display("FAIL rr_fair_%0d: got repeat of %0d want each once", t, o.win); end
        if (o.win >= 0) seen[o.win] = 1'b1;
      end
    end
    bus.REQ_IN = '0;
    model_ptr = 1;
  endtask

  task automatic test_timeout();
    obs_t o;
    r_we[0] = 1'b0; r_addr[0] = 8'h55;
    do_xfer(4'b0001, 1000, 8'h00, o);
    bus.REQ_IN = '0;
    n_checks++; if (o.cyc_len !== TO + 1 || o.hung !== 1'b0) begin
      n_fail++; $display("FAIL to_cyc_len: got %0d want %0d", o.cyc_len, TO + 1); end
    n_checks++; if (o.ack !== 4'b0001 || o.err !== 4'b0001) begin
      n_fail++; $display("FAIL to_ack_err: got ack=%b err=%b want 0001/0001", o.ack, o.err); end
    n_checks++; if (o.rd !== 8'hFF) begin n_fail++; $display("FAIL to_rdata: got %h want ff", o.rd); end
    @(negedge CLK_IN);
    n_checks++; if (bus.ERR_OUT !== 4'b0000) begin n_fail++; $display("FAIL to_err_pulse: got %b want 0000", bus.ERR_OUT); end
    model_rd  = 8'hFF;
    model_ptr = 1;
  endtask

  task automatic test_ack_on_timeout();
    obs_t o;
    r_we[0] = 1'b0;
    do_xfer(4'b0001, TO, 8'h5A, o);
    bus.REQ_IN = '0;
    n_checks++; if (o.cyc_len !== TO + 1) begin n_fail++; $display("FAIL ackto_cyc_len: got %0d want %0d", o.cyc_len, TO + 1); end
    n_checks++; if (o.ack !== 4'b0001 || o.err !== 4'b0000 || o.rd !== 8'h5A) begin
      n_fail++; $display("FAIL ackto_result: got ack=%b err=%b rd=%h want 0001/0000/5a", o.ack, o.err, o.rd); end
    model_rd  = 8'h5A;
    model_ptr = 1;
  endtask

  task automatic test_random();
    obs_t o;
    logic [NR-1:0] mask, oh;
    logic [DW-1:0] srd, exp_rd;
    int lat, exp_win;
    for (int it = 0; it < 40; it++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < NR; i++) begin
        r_we[i] = 1'($urandom); r_addr[i] = 8'($urandom); r_wdata[i] = 8'($urandom);
      end
      lat     = $urandom_range(0, 20);
      srd     = 8'($urandom);
      exp_win = rr_pick(mask, model_ptr);
      oh      = '0;
      oh[exp_win] = 1'b1;
      if (lat > TO) exp_rd = 8'hFF;
      else if (!r_we[exp_win]) exp_rd = srd;
      else exp_rd = model_rd;
      do_xfer(mask, lat, srd, o);
      n_checks++; if (o.hung !== 1'b0 || o.win !== exp_win) begin
        n_fail++; $display("FAIL rnd_gnt_%0d: got %0d hung=%b want %0d (mask %b)", it, o.win, o.hung, exp_win, mask); end
      n_checks++; if ({o.we, o.addr, o.wdata} !== {r_we[exp_win], r_addr[exp_win], r_wdata[exp_win]}) begin
        n_fail++; $display("FAIL rnd_bus_%0d: got %b/%h/%h want %b/%h/%h", it, o.we, o.addr, o.wdata,
                           r_we[exp_win], r_addr[exp_win], r_wdata[exp_win]); end
      n_checks++; if (o.cyc_len !== ((lat > TO) ? TO : lat) + 1 || o.stable !== 1'b1 || o.gnt_ok !== 1'b1) begin
        n_fail++; $display("FAIL rnd_cyc_%0d: got len=%0d stable=%b gnt_ok=%b want len=%0d", it, o.cyc_len,
                           o.stable, o.gnt_ok, ((lat > TO) ? TO : lat) + 1); end
      n_checks++; if (o.ack !== oh || o.err !== ((lat > TO) ? oh : 4'b0000) || o.rd !== exp_rd) begin
        n_fail++; $display("FAIL rnd_resp_%0d: got ack=%b err=%b rd=%h want ack=%b rd=%h lat=%0d", it, o.ack,
                           o.err, o.rd, oh, exp_rd, lat); end
      model_rd  = exp_rd;
      model_ptr = (exp_win + 1) % NR;
    end
    bus.REQ_IN = '0;
  endtask

  task automatic test_reset_mid_xfer();
    logic got;
    r_we[0] = 1'b1; r_addr[0] = 8'h77; r_wdata[0] = 8'h99;
    r_we[3] = 1'b0; r_addr[3] = 8'h31; r_wdata[3] = 8'h00;
    @(negedge CLK_IN);
    load_inputs();
    bus.BUS_ACK_IN = 1'b0;
    bus.REQ_IN     = 4'b0001;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK_IN);
      if (|bus.GNT_OUT) begin got = 1'b1; break; end
    end
    repeat (3) @(negedge CLK_IN);
    n_checks++; if (got !== 1'b1 || bus.BUS_CYC_OUT !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre: got gnt_seen=%b cyc=%b want 1/1", got, bus.BUS_CYC_OUT); end
    #2;
    RESET_IN = 1'b0;
    #1;
    n_checks++; if ({bus.GNT_OUT, bus.ACK_OUT, bus.ERR_OUT, bus.RDATA_OUT, bus.BUS_CYC_OUT, bus.BUS_WE_OUT,
                     bus.BUS_ADDR_OUT, bus.BUS_WDATA_OUT} !== 38'd0) begin
      n_fail++; $display("FAIL mid_async_clear: got gnt=%b cyc=%b addr=%h wdata=%h rd=%h want all 0",
                         bus.GNT_OUT, bus.BUS_CYC_OUT, bus.BUS_ADDR_OUT, bus.BUS_WDATA_OUT, bus.RDATA_OUT); end
    @(negedge CLK_IN);
    RESET_IN   = 1'b1;
    bus.REQ_IN = 4'b1000;
    @(negedge CLK_IN);
    n_checks++; if (bus.GNT_OUT !== 4'b1000 || bus.BUS_ADDR_OUT !== 8'h31) begin
      n_fail++; $display("FAIL mid_regrant: got gnt=%b addr=%h want 1000/31", bus.GNT_OUT, bus.BUS_ADDR_OUT); end
    bus.BUS_ACK_IN = 1'b1;
    @(negedge CLK_IN);
    bus.BUS_ACK_IN = 1'b0;
    bus.REQ_IN     = '0;
    n_checks++; if (bus.ACK_OUT !== 4'b1000) begin n_fail++; $display("FAIL mid_ack: got %b want 1000", bus.ACK_OUT); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_round_robin();
    test_timeout();
    test_ack_on_timeout();
    test_random();
    test_reset_mid_xfer();
    repeat (2) @(negedge CLK_IN);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
